// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Frame FSM states, scan-code prefixes and the bit positions of the prefix flags in dout.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam int EXT_BIT = 9;
    localparam int BRK_BIT = 8;

endpackage

// File: rtl/ps2_keyboard_rx_sync_fifo.sv
// Synchronous FIFO with a registered head word that always shows the oldest entry.
// The head keeps its last value when the FIFO drains; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_do_push;
    logic             w_do_pop;
    logic [AW-1:0]    w_rd_next;
    logic [CW-1:0]    w_count_next;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_head;

    always_comb begin
        w_do_pop     = pop && !empty;
        w_do_push    = push && (!full || w_do_pop);
        w_rd_next    = r_rd + AW'(w_do_pop);
        w_count_next = r_count + CW'(w_do_push) - CW'(w_do_pop);
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= din;
        end
    end

    // The incoming word becomes the head directly when it lands in the slot the read pointer moves to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_head  <= '0;
        end else begin
            r_rd    <= w_rd_next;
            r_count <= w_count_next;
            if (w_do_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_count_next != '0) begin
                r_head <= (w_do_push && (w_rd_next == r_wr)) ? din : r_mem[w_rd_next];
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: synchronisers, clock glitch filter, 11-bit frame FSM,
// E0/F0 prefix decoding and a scan-code FIFO popped by rising edges of the CPU ack level.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2c,
    input  logic        ps2d,
    input  logic        ack,
    output logic [15:0] dout,
    output logic        valid,
    output logic        IRQ_keyboard,
    output logic        overflow,
    output logic        frame_err
);

    localparam int FC_W = $clog2(FILTER_LEN + 1);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic            r_c_s1, r_c_s2, r_d_s1, r_d_s2;
    logic            r_filt, r_filt_d;
    logic [FC_W-1:0] r_filt_cnt;
    rx_state_t       r_state;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_par;
    logic [WD_W-1:0] r_wd;
    logic [7:0]      r_byte;
    logic            r_byte_ok;
    logic            r_frame_err;
    logic            r_ext, r_brk;
    logic            r_ack_q, r_ack_prev;
    logic            r_overflow;

    logic            w_strobe;
    logic            w_push;
    logic [9:0]      w_push_data;
    logic            w_pop;
    logic [9:0]      w_head;
    logic            w_full;
    logic            w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_s1 <= 1'b1;
            r_c_s2 <= 1'b1;
            r_d_s1 <= 1'b1;
            r_d_s2 <= 1'b1;
        end else begin
            r_c_s1 <= ps2c;
            r_c_s2 <= r_c_s1;
            r_d_s1 <= ps2d;
            r_d_s2 <= r_d_s1;
        end
    end

    // The filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt     <= 1'b1;
            r_filt_d   <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (r_c_s2 == r_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FC_W'(FILTER_LEN - 1)) begin
                r_filt     <= r_c_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_strobe = r_filt_d & ~r_filt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_wd        <= '0;
            r_byte      <= '0;
            r_byte_ok   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_ok   <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_strobe) begin
                r_wd <= '0;
                case (r_state)
                    IDLE: begin
                        if (!r_d_s2) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        r_shift <= {r_d_s2, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        r_par   <= r_d_s2;
                        r_state <= STOP;
                    end
                    STOP: begin
                        if (r_d_s2 && (^{r_shift, r_par})) begin
                            r_byte    <= r_shift;
                            r_byte_ok <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (r_state != IDLE) begin
                // A stalled partial frame is dropped silently.
                if (r_wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    r_state <= IDLE;
                    r_wd    <= '0;
                end else begin
                    r_wd <= r_wd + 1'b1;
                end
            end else begin
                r_wd <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (r_byte_ok) begin
            if (r_byte == PS2_PREFIX_EXT) begin
                r_ext <= 1'b1;
            end else if (r_byte == PS2_PREFIX_BRK) begin
                r_brk <= 1'b1;
            end else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    assign w_push = r_byte_ok && (r_byte != PS2_PREFIX_EXT) && (r_byte != PS2_PREFIX_BRK);

    always_comb begin
        w_push_data          = '0;
        w_push_data[EXT_BIT] = r_ext;
        w_push_data[BRK_BIT] = r_brk;
        w_push_data[7:0]     = r_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack_q    <= 1'b0;
            r_ack_prev <= 1'b0;
        end else begin
            r_ack_q    <= ack;
            r_ack_prev <= r_ack_q;
        end
    end

    assign w_pop = r_ack_q && !r_ack_prev && (w_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (10),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_push_data),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign dout         = {6'b0, w_head};
    assign valid        = !w_empty;
    assign IRQ_keyboard = !w_empty;
    assign overflow     = r_overflow;
    assign frame_err    = r_frame_err;

endmodule
